// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter types and sync-window helpers.
package vga_timing_pkg;

    // Counter width for both axes; totals must fit in this many bits
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1 << CNT_W;

    // Default 640x480@60 Hz timing, 25 MHz pixel rate from a 50 MHz clk
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [CNT_W-1:0] vga_cnt_t;

    // Next-state view of one axis: count plus its decoded flags
    typedef struct packed {
        vga_cnt_t count;
        logic     active;
        logic     sync;
    } vga_axis_t;

    // Full period of one axis in its own units (pixels or lines)
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // First count at which sync is asserted
    function automatic int unsigned sync_start(input int unsigned active,
                                               input int unsigned fp);
        return active + fp;
    endfunction

    // First count after the sync pulse (exclusive end)
    function automatic int unsigned sync_end(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync);
        return active + fp + sync;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with next-state active/sync decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned FP       = DEF_H_FP,
    parameter int unsigned SYNC     = DEF_H_SYNC,
    parameter int unsigned BP       = DEF_H_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_en,
    output logic      o_wrap_c,
    output vga_axis_t o_next_c
);

    localparam int unsigned TOTAL  = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_S = sync_start(ACTIVE, FP);
    localparam int unsigned SYNC_E = sync_end(ACTIVE, FP, SYNC);
    // One extra bit so bounds equal to MAX_TOTAL still compare correctly
    localparam int unsigned CMP_W  = CNT_W + 1;

    vga_cnt_t         r_count;
    vga_cnt_t         w_count_next;
    logic             w_last;
    logic [CMP_W-1:0] w_cmp;

    // Next count: hold, increment, or wrap to zero at the end of the period
    always_comb begin
        w_last       = (r_count == CNT_W'(TOTAL - 1));
        w_count_next = r_count;
        if (i_en) begin
            w_count_next = w_last ? '0 : r_count + CNT_W'(1);
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Decode flags from the next count so the top can register them in step
    always_comb begin
        w_cmp           = {1'b0, w_count_next};
        o_wrap_c        = i_en & w_last;
        o_next_c.count  = w_count_next;
        o_next_c.active = (w_cmp < CMP_W'(ACTIVE));
        o_next_c.sync   = ((w_cmp >= CMP_W'(SYNC_S)) && (w_cmp < CMP_W'(SYNC_E)))
                          ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel prescaler, H/V axis counters, registered outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             activeVideo,
    output logic             pixelTick,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned P_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Reject timings the 10-bit counters or the prescaler cannot represent
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL exceeds counter range");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL exceeds counter range");
    end

    logic [P_W-1:0]   r_p;
    logic [P_W-1:0]   w_p_next;
    logic             w_p_last;
    logic             w_tick_next;

    logic             r_pixel_tick;
    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_active;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_h_wrap;
    logic             w_v_wrap;
    vga_axis_t        w_h_next;
    vga_axis_t        w_v_next;

    // Prescaler next state; pixelTick is registered so it lines up with p==CLK_DIV-1
    always_comb begin
        w_p_last    = (r_p == P_W'(CLK_DIV - 1));
        w_p_next    = w_p_last ? '0 : r_p + P_W'(1);
        w_tick_next = (w_p_next == P_W'(CLK_DIV - 1));
    end

    // Prescaler and pixel tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p          <= '0;
            r_pixel_tick <= 1'b0;
        end else begin
            r_p          <= w_p_next;
            r_pixel_tick <= w_tick_next;
        end
    end

    // Horizontal axis advances once per pixel period
    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_pixel_tick),
        .o_wrap_c (w_h_wrap),
        .o_next_c (w_h_next)
    );

    // Vertical axis advances on the edge the horizontal axis wraps
    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_h_wrap),
        .o_wrap_c (w_v_wrap),
        .o_next_c (w_v_next)
    );

    // Output registers loaded from next-state decode for zero skew with the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_h_next.count;
            r_y           <= w_v_next.count;
            r_active      <= w_h_next.active & w_v_next.active;
            r_hsync       <= w_h_next.sync;
            r_vsync       <= w_v_next.sync;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap & w_v_wrap;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign activeVideo = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pixelTick   = r_pixel_tick;
    assign lineStart   = r_line_start;
    assign frameStart  = r_frame_start;

endmodule
